// File: rtl/tricolor_pkg.sv
// Shared types for the tricolor comparator: one-hot result encoding and helpers.
package tricolor_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'b000,
    BLUE  = 3'b001,
    GREEN = 3'b010,
    RED   = 3'b100
  } color_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  // Priority order only matters if the comparator ever broke one-hotness.
  function automatic color_t to_color(input cmp_res_t r);
    if (r.gt)      return RED;
    else if (r.lt) return BLUE;
    else if (r.eq) return GREEN;
    else           return NONE;
  endfunction

  // {red, green, blue}
  function automatic logic [2:0] color_bits(input color_t c);
    return {c == RED, c == GREEN, c == BLUE};
  endfunction

endpackage

// File: rtl/tricolor_cmp.sv
// Combinational magnitude compare: MSB-first cascade, sign bits flipped for signed mode.
module tricolor_cmp
  import tricolor_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [WIDTH-1:0] ax, bx;
  logic             g, l;

  always_comb begin
    ax = a;
    bx = b;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (SIGNED_CMP) begin
      ax[WIDTH-1] = ~a[WIDTH-1];
      bx[WIDTH-1] = ~b[WIDTH-1];
    end
    g = 1'b0;
    l = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!g && !l) begin
        g = ax[i] & ~bx[i];
        l = ~ax[i] & bx[i];
      end
    end
    gt = g;
    lt = l;
    eq = (a == b);
    assert ($onehot({gt, eq, lt}));
  end

endmodule

// File: rtl/tricolor.sv
// Registered comparator: one-hot red (a>b) / green (a==b) / blue (a<b), 1-cycle latency.
module tricolor
  import tricolor_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             red,
  output logic             green,
  output logic             blue
);

  cmp_res_t res;
  color_t   col_d, col_q;

  tricolor_cmp #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cmp (
    .a  (a),
    .b  (b),
    .gt (res.gt),
    .eq (res.eq),
    .lt (res.lt)
  );

  assign col_d = to_color(res);

  always_ff @(posedge clk) begin
    if (rst) col_q <= NONE;
    else     col_q <= col_d;
  end

  assign {red, green, blue} = color_bits(col_q);

  // Any edge sampled out of reset must have loaded a one-hot result.
  assert property (@(posedge clk) !rst |=> $onehot({red, green, blue}));

endmodule

// File: tb/tb_tricolor.sv
// Bench for tricolor: unsigned and signed WIDTH=2 instances driven with shared operands.
module tb_tricolor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a   = 2'b00;
  logic [1:0] b   = 2'b00;
  logic       u_red, u_green, u_blue;
  logic       s_red, s_green, s_blue;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  tricolor #(.WIDTH(2), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .red(u_red), .green(u_green), .blue(u_blue)
  );

  tricolor #(.WIDTH(2), .SIGNED_CMP(1'b1)) s_dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .red(s_red), .green(s_green), .blue(s_blue)
  );

  typedef struct {
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] eu;   // expected {red,green,blue}, unsigned instance
    logic [2:0] es;   // expected {red,green,blue}, signed instance
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb[$];

  // Reference model uses the language's own relational operators.
  function automatic logic [2:0] model(input logic r, input logic [1:0] x,
                                       input logic [1:0] y, input logic sgn);
    logic signed [1:0] sx, sy;
    sx = x;
    sy = y;
    if (r) return 3'b000;
    if (sgn) return {sx > sy, sx == sy, sx < sy};
    return {x > y, x == y, x < y};
  endfunction

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got rgb=%b expected rgb=%b", name, got, exp);
    end
  endtask

  // Drive at negedge, push expectation, sample #1 after the next posedge.
  task automatic apply(input string name, input vec_t v);
    logic [5:0] e;
    @(negedge clk);
    rst = v.rst;
    a   = v.a;
    b   = v.b;
    sb.push_back({v.eu, v.es});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("%s u a=%b b=%b rst=%b", name, v.a, v.b, v.rst), {u_red, u_green, u_blue}, e[5:3]);
    check($sformatf("%s s a=%b b=%b rst=%b", name, v.a, v.b, v.rst), {s_red, s_green, s_blue}, e[2:0]);
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] x, input logic [1:0] y);
    vec_t v;
    v.rst = r;
    v.a   = x;
    v.b   = y;
    v.eu  = model(r, x, y, 1'b0);
    v.es  = model(r, x, y, 1'b1);
    return v;
  endfunction

  initial begin
    vec_t v;
    int   rst_at;

    // Directed table: hand-derived expectations.
    tbl.push_back('{1'b1, 2'b11, 2'b00, 3'b000, 3'b000});
    tbl.push_back('{1'b1, 2'b11, 2'b00, 3'b000, 3'b000});
    tbl.push_back('{1'b0, 2'b11, 2'b00, 3'b100, 3'b001});  // 3>0 ; -1<0
    tbl.push_back('{1'b0, 2'b10, 2'b01, 3'b100, 3'b001});  // 2>1 ; -2<1
    tbl.push_back('{1'b0, 2'b01, 2'b10, 3'b001, 3'b100});  // 1<2 ; 1>-2
    tbl.push_back('{1'b0, 2'b00, 2'b00, 3'b010, 3'b010});
    tbl.push_back('{1'b0, 2'b01, 2'b01, 3'b010, 3'b010});
    tbl.push_back('{1'b0, 2'b10, 2'b10, 3'b010, 3'b010});
    tbl.push_back('{1'b0, 2'b11, 2'b11, 3'b010, 3'b010});
    tbl.push_back('{1'b0, 2'b11, 2'b10, 3'b100, 3'b100});  // 3>2 ; -1>-2
    tbl.push_back('{1'b0, 2'b01, 2'b11, 3'b001, 3'b100});  // 1<3 ; 1>-1
    tbl.push_back('{1'b0, 2'b10, 2'b11, 3'b001, 3'b001});  // 2<3 ; -2<-1
    tbl.push_back('{1'b0, 2'b00, 2'b10, 3'b001, 3'b100});  // 0<2 ; 0>-2
    foreach (tbl[i]) apply("directed", tbl[i]);

    // Exhaustive pairs on consecutive cycles.
    for (int i = 0; i < 16; i++) apply("exhaustive", mk(1'b0, i[3:2], i[1:0]));

    // Operands changing between edges must not disturb the registered result.
    apply("hold_setup", mk(1'b0, 2'b10, 2'b01));
    #2;
    a = 2'b00;
    b = 2'b11;
    #1;
    check("hold_u", {u_red, u_green, u_blue}, 3'b100);
    check("hold_s", {s_red, s_green, s_blue}, 3'b001);

    // Random run with a single-cycle reset mid-stream, then recovery.
    rst_at = 5;
    for (int i = 0; i < 11; i++) begin
      v = mk(i == rst_at, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      apply(i == rst_at ? "mid_reset" : (i == rst_at + 1 ? "post_reset" : "random"), v);
    end

    // Reset wins even with operands that would give a result.
    apply("reset_wins", '{1'b1, 2'b01, 2'b00, 3'b000, 3'b000});
    apply("release", '{1'b0, 2'b01, 2'b00, 3'b100, 3'b100});

    nvec++;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/tricolor.md
# tricolor

Registered two-operand magnitude comparator that reports the relation between inputs `a` and `b` on three one-hot indicator lines:
- `red` means a > b.
- `green` means a == b.
- `blue` means a < b.

It sits as a small status/indicator block, for example driving an RGB LED or a downstream decision stage. The comparison is performed every clock cycle, and the result is registered.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `WIDTH`, default 2: operand width in bits, ≥ 1.
- `SIGNED_CMP`, default 0: 0 compares operands as unsigned; 1 compares them as two's-complement signed.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  WIDTH  first operand.
- `b`  input  WIDTH  second operand.
- `red`  output  1  registered; 1 when a > b.
- `green`  output  1  registered; 1 when a == b.
- `blue`  output  1  registered; 1 when a < b.

## Operation
- Each rising edge of `clk` with `rst`=0 samples `a` and `b`, compares them, and loads the result into the three output flops.
- Exactly one of `red`/`green`/`blue` is 1 in every cycle after the first post-reset sample. This one-hot property is mandatory and holds for all operand values.
- Unsigned mode (`SIGNED_CMP`=0):
  - Plain binary magnitude.
  - WIDTH=2 example: a=2'b10, b=2'b01 gives red.
  - Values range 0 … 2^WIDTH−1; no overflow is possible.
- Signed mode (`SIGNED_CMP`=1):
  - The MSB is the sign bit.
  - WIDTH=2 example: a=2'b10 (−2), b=2'b01 (+1) gives blue.
  - Boundary: the most-negative value (e.g. 2'b10) is less than every other value. The most-positive value (2'b01) is greater than every other value.
- Equality is bitwise and independent of `SIGNED_CMP`.
- X/Z on the inputs is not required to be handled. The outputs may go X in simulation only.

## Timing
- Latency is 1 cycle: outputs reflect the `a`/`b` values sampled at the previous rising edge. Outputs are glitch-free, driven directly by flops.
- Reset: while `rst`=1 at a rising edge, `red`=0, `green`=0, `blue`=0 (the "no result" state).
- First valid result: on the first rising edge with `rst`=0, the outputs load the comparison of the operands sampled at that edge.
- Reset asserted mid-operation: outputs clear to 000 at the next rising edge, regardless of the operands. No other state exists.
- Operand changes between edges have no effect on the outputs until the next edge. Operands must be held at least one full clock period to be observed.
- Back-to-back operand changes every cycle are supported. Each cycle's result is independent, and there is no history or hysteresis.
- No handshake; the block is always ready.

## Structure
- Shared package `tricolor_pkg`:
  - `typedef enum logic [2:0] color_t`, one-hot {RED=3'b100, GREEN=3'b010, BLUE=3'b001, NONE=3'b000}.
  - A function that maps `color_t` to the {red, green, blue} bit order.
- Sub-module `tricolor_cmp`:
  - Purely combinational.
  - Parameterised by `WIDTH` and `SIGNED_CMP`.
  - Produces `gt`/`eq`/`lt` using an MSB-first bitwise cascade. In signed mode the sign bits are inverted before the cascade.
  - Includes an internal assertion that exactly one of `gt`/`eq`/`lt` is set.
- Top-level `tricolor`:
  - Instantiates `tricolor_cmp`.
  - Encodes the result to `color_t`.
  - Holds one 3-bit output register with synchronous reset to NONE.
  - Includes a concurrent assertion: after reset is released, {red,green,blue} is one-hot (`$onehot`).

## Test plan
- Reset check: hold `rst`=1 for 2 cycles with a=2'b11, b=2'b00 → outputs 000 throughout; release `rst` → red=1 one cycle later.
- Directed, unsigned, WIDTH=2:
  - a=2'b10, b=2'b01 → red=1, green=0, blue=0 after 1 cycle.
  - Then a=2'b01, b=2'b10 → blue=1 on the next cycle.
- Equality, unsigned, WIDTH=2: a=b for each of 0, 1, 2, 3 → green=1 only, for every value.
- Exhaustive, unsigned, WIDTH=2: all 16 (a,b) pairs applied on consecutive cycles → each output matches a golden model with 1-cycle lag; one-hot holds every cycle.
- Signed boundary, `SIGNED_CMP`=1, WIDTH=2:
  - a=2'b10, b=2'b01 → blue.
  - a=2'b11, b=2'b10 → red.
  - a=2'b01, b=2'b11 → red.
- Mid-operation reset and random run:
  - Run 10 random pairs, assert `rst` for one cycle mid-stream → outputs 000 for exactly that cycle.
  - The next pair after release compares correctly.
